// File: rtl/eth_egress_queue.sv
// rtl/eth_egress_queue.sv - per-port egress queue: address filter, packet FIFO, two-beat SOP/EOP egress
module eth_egress_queue #(
  parameter logic [31:0] PORT_ADDR = 32'hABCD,
  parameter int          DEPTH     = 4,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_wr_en,
  input  logic [66:0]      in_data,
  output logic [31:0]      outdata,
  output logic             outsop,
  output logic             outeop,
  output logic             outvalid,
  input  logic             outready,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] pkt_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND_ADDR = 2'd1;
  localparam logic [1:0] SEND_DATA = 2'd2;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [1:0]    state;
  logic [63:0]   head;
  logic          match;
  logic          push;
  logic          pop;
  logic          unused_bits;

  // sop/eop are regenerated on egress, so only {data, dest} is kept
  assign unused_bits = ^{in_data[66:65], in_data[0]};

  assign match = in_wr_en && (in_data[32:1] == PORT_ADDR);
  assign push  = match && !fifo_full;
  assign pop   = (state == SEND_DATA) && outready;
  assign head  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + ONE_CNT;
    else if (pop && !push)
      count_next = count - ONE_CNT;
  end

  // A write never lands on the head slot while the FIFO is non-empty and not full
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data[64:1];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      drop_cnt   <= '0;
      pkt_cnt    <= '0;
    end else begin
      count      <= count_next;
      fifo_full  <= (count_next == FULL_CNT);
      fifo_empty <= (count_next == '0);
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (match && fifo_full && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
      if (pop && (pkt_cnt != '1))
        pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:      if (!fifo_empty) state <= SEND_ADDR;
        SEND_ADDR: if (outready) state <= SEND_DATA;
        SEND_DATA: if (outready) state <= (count > ONE_CNT) ? SEND_ADDR : IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on state and the stored head, so they hold during stalls
  always_comb begin
    outvalid = 1'b0;
    outsop   = 1'b0;
    outeop   = 1'b0;
    outdata  = 32'd0;
    case (state)
      SEND_ADDR: begin
        outvalid = 1'b1;
        outsop   = 1'b1;
        outdata  = head[31:0];
      end
      SEND_DATA: begin
        outvalid = 1'b1;
        outeop   = 1'b1;
        outdata  = head[63:32];
      end
      default: ;
    endcase
  end

endmodule

// File: doc/eth_egress_queue.md
# eth_egress_queue

Per-output-port egress queue for the 2x2 Ethernet switch. It sits directly downstream of the receive FSM and consumes its 67-bit packet word (`out_wr_en` / `out_data`). It keeps packets whose destination matches this port's address and buffers them in a small FIFO. It then re-serializes each packet as a two-beat stream (address beat with SOP, data beat with EOP) under a valid/ready handshake. One instance is placed per output port, with `PORT_ADDR` set to 32'hABCD for port A and 32'hEFEF for port B.

## Interface
Reset is `rstn`: synchronous, active-low. The clock is `clk`.

Parameters:
- PORT_ADDR, 32'hABCD: destination address owned by this port.
- DEPTH, 4: FIFO depth in packets; must be a power of 2 and at least 2.
- CNT_W, 8: width of the statistics counters.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rstn  in  1  synchronous active-low reset.
- in_wr_en  in  1  one-cycle strobe: packet word valid.
- in_data  in  67  packet word, laid out as follows:
  - [66]: unused, always 0.
  - [65]: eop.
  - [64:33]: data.
  - [32:1]: destination address.
  - [0]: sop.
- outdata  out  32  egress beat payload.
- outsop  out  1  marks the address beat.
- outeop  out  1  marks the data beat.
- outvalid  out  1  beat valid.
- outready  in  1  sink accepts the beat when outvalid and outready are both 1.
- fifo_full  out  1  FIFO holds DEPTH packets.
- fifo_empty  out  1  FIFO holds 0 packets.
- drop_cnt  out  CNT_W  count of matching packets dropped because the FIFO was full; saturates.
- pkt_cnt  out  CNT_W  count of packets fully transmitted; saturates.

## Operation
- Match: a packet matches when in_wr_en is 1 and in_data[32:1] == PORT_ADDR. Non-matching strobes are ignored silently: no count and no state change.
- Write:
  - A matching packet is written only if fifo_full is 0.
  - The entry stores {data, dest}, 64 bits. The sop and eop bits are not stored; they are regenerated on egress.
- Full drop:
  - A matching packet that arrives while fifo_full is 1 is dropped and drop_cnt increments.
  - This applies even if a pop happens in the same cycle. fifo_full is evaluated from the registered state, with no bypass.
- FIFO pointers:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - The occupancy count is log2(DEPTH)+1 bits.
  - fifo_full is (count == DEPTH); fifo_empty is (count == 0). Both are registered.
- Simultaneous push and pop (push allowed because FIFO not full): count is unchanged and both pointers advance.
- Egress FSM states are IDLE, SEND_ADDR and SEND_DATA:
  - IDLE: outvalid = 0. If fifo_empty is 0, go to SEND_ADDR; otherwise stay in IDLE.
  - SEND_ADDR: outvalid = 1, outsop = 1, outeop = 0, outdata = head.dest. If outready is 1, go to SEND_DATA; otherwise stay.
  - SEND_DATA: outvalid = 1, outsop = 0, outeop = 1, outdata = head.data. If outready is 1:
    - Pop the head and increment pkt_cnt.
    - Go to SEND_ADDR if count > 1, otherwise to IDLE.
  - If outready is 0 in SEND_DATA, stay.
- Stall rule: while outvalid = 1 and outready = 0, outdata, outsop and outeop hold stable.
- Head stability: the head entry never changes while the FSM is in SEND_ADDR or SEND_DATA.
- Counters: both saturate at 2^CNT_W − 1 and never wrap.
- Reset: takes effect mid-packet as well. It discards all FIFO contents and any partially sent packet, and returns the FSM to IDLE.

## Timing
- Reset values:
  - outvalid, outsop, outeop = 0; outdata = 32'd0.
  - fifo_full = 0; fifo_empty = 1.
  - drop_cnt = 0; pkt_cnt = 0.
  - Both pointers and count = 0; state = IDLE.
- Write at edge E0: fifo_empty falls after E0. The FSM leaves IDLE at E1, so outvalid (address beat) is first visible in the cycle after E1.
- Minimum latency from write edge to first beat: 2 cycles. A packet with continuous outready completes in 2 further edges.
- Back-to-back packets with outready held at 1 stream gaplessly: addr, data, addr, data, …
- Outputs are a function of registered state and the registered FIFO head only; there is no combinational path from outready or in_data to any output.
- Throughput: one packet per 2 cycles. The upstream writes at most one packet per 4 cycles, so drops occur only under sink backpressure.

## Test plan
- Single match: write dest = 32'hABCD, data = 32'h1234_5678, outready = 1.
  - Expect outvalid 2 cycles after the write edge.
  - Beat 1: outsop = 1, outdata = 32'hABCD. Beat 2: outeop = 1, outdata = 32'h1234_5678.
  - Then pkt_cnt = 1 and fifo_empty = 1.
- Non-match: write dest = 32'hEFEF to the PORT_ADDR = 32'hABCD instance.
  - outvalid stays 0; drop_cnt = 0; fifo_empty = 1.
- Full and drop: outready = 0; write 5 matching packets with data 1..5.
  - fifo_full = 1 after the 4th write; drop_cnt = 1.
  - Release outready: data 1, 2, 3, 4 egress in order and pkt_cnt = 4.
- Backpressure: toggle outready 0/1 every cycle during 2 packets.
  - Each beat is held stable until accepted; no beat is duplicated or lost; there is no gap between packets when outready = 1.
- Wrap and simultaneous push/pop: stream 10 packets while the sink drains continuously.
  - Pointers wrap; data order is preserved; pkt_cnt = 10.
- Reset mid-packet: assert rstn = 0 while in SEND_DATA.
  - All outputs return to their reset values on the next edge; the FIFO is empty; after release no stale beat is emitted.
